// File: rtl/intc_pkg.sv
// Shared definitions for the IOBUS interrupt controller: register offsets,
// control-bit positions and the claim priority encoder.
package intc_pkg;

    localparam int unsigned MAX_SRC      = 32;
    localparam int unsigned CTRL_GIE_BIT = 0;

    typedef enum logic [2:0] {
        OFS_PENDING = 3'd0,
        OFS_ENABLE  = 3'd1,
        OFS_EDGE    = 3'd2,
        OFS_CTRL    = 3'd3,
        OFS_CLAIM   = 3'd4,
        OFS_RAW     = 3'd5
    } intc_ofs_e;

    // Returns (index+1) of the lowest set bit, or 0 when no bit is set.
    function automatic logic [31:0] claim_id(input logic [MAX_SRC-1:0] act);
        logic [31:0] id;
        id = 32'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                id = 32'(i) + 32'd1;
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/iobus_intc_if.sv
// IOBUS connection between the pipelined core (master) and a memory-mapped
// peripheral (slave).
interface iobus_intc_if;

    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN
    );

endinterface

// File: rtl/irq_sample_edge.sv
// Per-source sampler: optional 2-flop synchronizer (INTC_SYNC_EN), sample and
// previous-sample flops, and the rise/level pending-set pulse.
module irq_sample_edge (
    input  logic clk,
    input  logic RESET_N,
    input  logic irq_i,
    input  logic edge_i,
    output logic raw_o,
    output logic set_o
);

    logic s_in_s;
    logic s_irq_q;
    logic prev_q;

`ifdef INTC_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for an asynchronous request line.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], irq_i};
        end
    end

    assign s_in_s = sync_q[1];
`else
    assign s_in_s = irq_i;
`endif

    // Sample register and its one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            s_irq_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            s_irq_q <= s_in_s;
            prev_q  <= s_irq_q;
        end
    end

    // Edge sources set only on 0->1 of the sample; level sources set while high.
    always_comb begin
        set_o = 1'b0;
        if (edge_i) begin
            set_o = s_irq_q & ~prev_q;
        end else begin
            set_o = s_irq_q;
        end
    end

    assign raw_o = s_irq_q;

endmodule

// File: rtl/iobus_intc.sv
// Memory-mapped interrupt controller on the core IOBUS: register file, address
// decode, claim encoder and registered INTR. INTC_SYNC_EN adds input synchronizers.
module iobus_intc
    import intc_pkg::*;
#(
    parameter int unsigned N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic             clk,
    input  logic             RESET_N,
    iobus_intc_if.slave      bus,
    input  logic [N_SRC-1:0] IRQ_SRC,
    output logic             INTR
);

    logic             sel_s;
    logic [2:0]       ofs_s;
    logic             wr_s;
    logic [N_SRC-1:0] raw_s;
    logic [N_SRC-1:0] set_s;
    logic [N_SRC-1:0] act_s;
    logic [31:0]      claim_s;
    logic [31:0]      rdata_s;
    logic             addr_unused_s;

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q,  enable_d;
    logic [N_SRC-1:0] edge_q,    edge_d;
    logic             gie_q,     gie_d;
    logic             intr_q,    intr_d;

    assign sel_s         = (bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign ofs_s         = bus.IOBUS_ADDR[4:2];
    assign wr_s          = bus.IOBUS_WR & sel_s;
    assign addr_unused_s = ^{bus.IOBUS_ADDR[1:0], bus.IOBUS_OUT};

    for (genvar g = 0; g < int'(N_SRC); g++) begin : g_src
        irq_sample_edge u_smp (
            .clk     (clk),
            .RESET_N (RESET_N),
            .irq_i   (IRQ_SRC[g]),
            .edge_i  (edge_q[g]),
            .raw_o   (raw_s[g]),
            .set_o   (set_s[g])
        );
    end

    assign act_s = pending_q & enable_q;

    // Priority encoder over enabled pending sources, widened to the package maximum.
    always_comb begin
        logic [MAX_SRC-1:0] act_ext;
        act_ext              = '0;
        act_ext[N_SRC-1:0]   = act_s;
        claim_s              = claim_id(act_ext);
    end

    // Register next state; a new set event beats a same-cycle W1C on that bit.
    always_comb begin
        pending_d = pending_q;
        enable_d  = enable_q;
        edge_d    = edge_q;
        gie_d     = gie_q;
        if (wr_s) begin
            case (ofs_s)
                OFS_PENDING: pending_d = pending_q & ~bus.IOBUS_OUT[N_SRC-1:0];
                OFS_ENABLE:  enable_d  = bus.IOBUS_OUT[N_SRC-1:0];
                OFS_EDGE:    edge_d    = bus.IOBUS_OUT[N_SRC-1:0];
                OFS_CTRL:    gie_d     = bus.IOBUS_OUT[CTRL_GIE_BIT];
                default:     pending_d = pending_q;
            endcase
        end else begin
            pending_d = pending_q;
        end
        pending_d = pending_d | set_s;
        intr_d    = gie_q & (|act_s);
    end

    // Register file and INTR flop.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            gie_q     <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            gie_q     <= gie_d;
            intr_q    <= intr_d;
        end
    end

    // Side-effect-free read mux; zero outside the window so peripherals can be OR-ed.
    always_comb begin
        rdata_s = 32'd0;
        if (sel_s) begin
            case (ofs_s)
                OFS_PENDING: rdata_s[N_SRC-1:0]   = pending_q;
                OFS_ENABLE:  rdata_s[N_SRC-1:0]   = enable_q;
                OFS_EDGE:    rdata_s[N_SRC-1:0]   = edge_q;
                OFS_CTRL:    rdata_s[CTRL_GIE_BIT] = gie_q;
                OFS_CLAIM:   rdata_s               = claim_s;
                OFS_RAW:     rdata_s[N_SRC-1:0]   = raw_s;
                default:     rdata_s               = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.IOBUS_IN = rdata_s;
    assign INTR         = intr_q;

endmodule

// File: tb/tb_iobus_intc.sv
// Randomized self-checking bench for iobus_intc against a cycle-level reference
// model of the register rules; honours INTC_SYNC_EN for the extra input latency.
module tb_iobus_intc;

    localparam int unsigned N    = 8;
    localparam logic [31:0] BASE = 32'h1100_0100;
`ifdef INTC_SYNC_EN
    localparam int SYNC_X = 2;
`else
    localparam int SYNC_X = 0;
`endif
    localparam int LAT = 2 + SYNC_X;

    logic         clk = 1'b0;
    logic         RESET_N;
    logic [N-1:0] IRQ_SRC;
    logic         INTR;

    iobus_intc_if bus ();

    iobus_intc #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus),
        .IRQ_SRC (IRQ_SRC),
        .INTR    (INTR)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural registers plus the sampled input history.
    logic [N-1:0] m_pend, m_en, m_edge, m_raw, m_prev, m_s1, m_s2;
    logic         m_gie, m_intr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0; m_raw = '0; m_prev = '0;
        m_s1 = '0; m_s2 = '0; m_gie = 1'b0; m_intr = 1'b0;
    endtask

    function automatic logic [31:0] m_claim();
        logic [N-1:0] a;
        a = m_pend & m_en;
        for (int i = 0; i < int'(N); i++) begin
            if (a[i]) return 32'(i + 1);
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input int o);
        case (o)
            0:       return 32'(m_pend);
            1:       return 32'(m_en);
            2:       return 32'(m_edge);
            3:       return {31'd0, m_gie};
            4:       return m_claim();
            5:       return 32'(m_raw);
            default: return 32'd0;
        endcase
    endfunction

    task automatic rd(input int o, output logic [31:0] v);
        logic [31:0] a;
        a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
        bus.IOBUS_ADDR = a;
        #1;
        v = bus.IOBUS_IN;
    endtask

    // Reads every offset plus one outside the window and compares INTR; spans 9 time units.
    task automatic sweep();
        logic [31:0] v;
        for (int o = 0; o < 8; o++) begin
            rd(o, v);
            check_eq($sformatf("rd_ofs%0d", o), v, m_read(o));
        end
        bus.IOBUS_ADDR = BASE + 32'd32;
        #1;
        check_eq("rd_outside", bus.IOBUS_IN, 32'd0);
        check_eq("intr", {31'd0, INTR}, {31'd0, m_intr});
    endtask

    // Applies one bus cycle and IRQ pattern, advances the model one clock, then checks.
    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [N-1:0] irq);
        logic         hit;
        int           o;
        logic [N-1:0] set, n_pend, n_en, n_edge;
        logic         n_gie, n_intr;
        bus.IOBUS_ADDR = a; bus.IOBUS_OUT = d; bus.IOBUS_WR = w; IRQ_SRC = irq;
        hit    = w && (a[31:5] == BASE[31:5]);
        o      = int'(a[4:2]);
        set    = m_raw & (~m_edge | ~m_prev);
        n_pend = m_pend;
        if (hit && o == 0) n_pend = m_pend & ~d[N-1:0];
        n_pend = n_pend | set;
        n_en   = (hit && o == 1) ? d[N-1:0] : m_en;
        n_edge = (hit && o == 2) ? d[N-1:0] : m_edge;
        n_gie  = (hit && o == 3) ? d[0] : m_gie;
        n_intr = m_gie && ((m_pend & m_en) != '0);
        @(posedge clk);
        m_pend = n_pend; m_en = n_en; m_edge = n_edge; m_gie = n_gie; m_intr = n_intr;
        m_prev = m_raw;
        if (SYNC_X != 0) begin
            m_raw = m_s2; m_s2 = m_s1; m_s1 = irq;
        end else begin
            m_raw = irq;
        end
        #1;
        bus.IOBUS_WR = 1'b0;
        sweep();
    endtask

    task automatic wr(input int o, input logic [31:0] d, input logic [N-1:0] irq);
        tick(BASE + 32'(o * 4), d, 1'b1, irq);
    endtask

    task automatic idle(input logic [N-1:0] irq);
        tick(BASE, 32'd0, 1'b0, irq);
    endtask

    // Mid-cycle asynchronous reset, checked before any clock edge can act.
    task automatic do_reset();
        #1 RESET_N = 1'b0;
        model_reset();
        #1;
        check_eq("rst_intr_async", {31'd0, INTR}, 32'd0);
        sweep();
        #1 RESET_N = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          lat;
        RESET_N = 1'b0; IRQ_SRC = '0;
        bus.IOBUS_ADDR = 32'd0; bus.IOBUS_OUT = 32'd0; bus.IOBUS_WR = 1'b0;
        model_reset();
        #3 sweep();
        #3 RESET_N = 1'b1;

        // Edge source 2, single-cycle pulse, then W1C.
        wr(2, 32'h04, '0); wr(1, 32'h04, '0); wr(3, 32'h01, '0);
        idle(8'h04);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            idle('0);
            if (INTR === 1'b1) lat = c;
        end
        check_eq("intr_latency", 32'(lat), 32'(LAT));
        rd(0, v); check_eq("pend_src2", v, 32'h04);
        rd(4, v); check_eq("claim_src2", v, 32'd3);
        wr(0, 32'h04, '0);
        rd(4, v); check_eq("claim_after_w1c", v, 32'd0);
        idle('0);
        check_eq("intr_after_w1c", {31'd0, INTR}, 32'd0);

        // Level source 5 held high survives W1C.
        wr(2, 32'h00, '0); wr(1, 32'h20, '0);
        for (int c = 0; c < 3 + SYNC_X; c++) idle(8'h20);
        wr(0, 32'h20, 8'h20);
        rd(0, v); check_eq("level_reassert", v & 32'h20, 32'h20);
        idle(8'h20);
        check_eq("level_intr_held", {31'd0, INTR}, 32'd1);
        for (int c = 0; c < 3 + SYNC_X; c++) idle('0);
        wr(0, 32'h20, '0);
        idle('0); idle('0);
        check_eq("level_intr_drop", {31'd0, INTR}, 32'd0);

        // Sources 1 and 6 pending: priority and enable gating.
        wr(2, 32'h42, '0); wr(1, 32'h42, '0);
        idle(8'h42);
        for (int c = 0; c < 3 + SYNC_X; c++) idle('0);
        rd(4, v); check_eq("claim_prio", v, 32'd2);
        wr(0, 32'h02, '0);
        rd(4, v); check_eq("claim_next", v, 32'd7);
        wr(1, 32'h00, '0); idle('0);
        rd(4, v); check_eq("claim_masked", v, 32'd0);
        rd(0, v); check_eq("pend_latched", v, 32'h40);
        check_eq("intr_masked", {31'd0, INTR}, 32'd0);

        // W1C colliding with a fresh edge on source 3: the set wins.
        wr(0, 32'hFF, '0); wr(2, 32'h08, '0); wr(1, 32'h08, '0);
        idle('0); idle('0); idle('0);
        wr(0, 32'hFF, '0);
        for (int c = 0; c < 1 + SYNC_X; c++) idle(8'h08);
        wr(0, 32'h08, 8'h08);
        rd(0, v); check_eq("set_beats_clear", v & 32'h08, 32'h08);
        tick(BASE + 32'd32, 32'hFFFF_FFFF, 1'b1, 8'h08);
        rd(1, v); check_eq("outside_wr_ignored", v, 32'h08);

        // Reset with INTR high.
        idle('0); idle('0);
        check_eq("intr_before_reset", {31'd0, INTR}, 32'd1);
        do_reset();

        // Randomized traffic, with one more asynchronous reset midway.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            logic [N-1:0] irq;
            irq = N'($urandom);
            if ($urandom_range(0, 7) != 0) a = BASE + 32'($urandom_range(0, 31));
            else                           a = $urandom;
            if ($urandom_range(0, 3) == 0) irq = '0;
            tick(a, $urandom, ($urandom_range(0, 2) == 0), irq);
            if (k == 200) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
